// File: rtl/accel_atan_sequencer.sv
// accel_atan_sequencer
// Shares one arctan core across the X/Y/Z tilt computations. Each sample
// strobe captures the accelerometer words and issues three jobs in X, Y, Z
// order. The three results are then presented together with a one-cycle
// valid pulse.
module accel_atan_sequencer #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        sample_stb,
  input  logic [9:0]  x_accel_data,
  input  logic [9:0]  y_accel_data,
  input  logic [9:0]  z_accel_data,
  output logic [15:0] core_x_in,
  output logic [15:0] core_y_in,
  output logic        core_start,
  input  logic [15:0] core_phase,
  input  logic        core_rdy,
  output logic [15:0] x_phase,
  output logic [15:0] y_phase,
  output logic [15:0] z_phase,
  output logic        phase_valid,
  output logic        busy,
  output logic        timeout_err,
  output logic        overrun,
  input  logic        clr_flags
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] AX_X = 2'd0;
  localparam logic [1:0] AX_Y = 2'd1;
  localparam logic [1:0] AX_Z = 2'd2;

  // Last WAIT count value; reaching it without a ready abandons the job
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [1:0]  axis_q;
  logic [7:0]  cnt_q;
  logic [9:0]  cap_x_q, cap_y_q, cap_z_q;
  logic [15:0] res_x_q, res_y_q;
  logic [15:0] core_x_in_q, core_y_in_q;
  logic        core_start_q;
  logic [15:0] x_phase_q, y_phase_q, z_phase_q;
  logic        phase_valid_q, busy_q, timeout_err_q, overrun_q;

  logic [1:0]  axis_d;
  logic [15:0] op_x_d, op_y_d;
  logic [15:0] res_val_s;
  logic        timeout_s, job_end_s, drop_s;

  // Scale a sign-magnitude accel word into a signed 16-bit core operand.
  // Bit 8 of the magnitude is deliberately ignored.
  function automatic logic [15:0] scale_op(input logic [9:0] a);
    logic [15:0] m;
    logic [15:0] s;
    m = {8'h00, a[7:2], 2'b00} * 16'd164;
    s = {1'b0, m[15:1]};
    return a[9] ? (16'h0000 - s) : s;
  endfunction

  // Operand pair for the job after the current one, from the captured words
  always_comb begin
    axis_d = axis_q + 2'd1;
    op_x_d = 16'h0000;
    op_y_d = 16'h0000;
    case (axis_d)
      AX_Y: begin
        op_x_d = scale_op(cap_z_q);
        op_y_d = scale_op(cap_x_q);
      end
      AX_Z: begin
        op_x_d = scale_op(cap_x_q);
        op_y_d = scale_op(cap_y_q);
      end
      default: begin
        op_x_d = scale_op(cap_y_q);
        op_y_d = scale_op(cap_z_q);
      end
    endcase
  end

  // Job completion, timeout and dropped-strobe events for this cycle
  always_comb begin
    timeout_s = (state_q == S_WAIT) && !core_rdy && (cnt_q == CNT_LAST);
    job_end_s = (state_q == S_WAIT) && (core_rdy || timeout_s);
    res_val_s = core_rdy ? core_phase : 16'h0000;
    drop_s    = sample_stb && (state_q != S_IDLE);
  end

  // Sequencer FSM with registered outputs and sticky flags
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q       <= S_IDLE;
      axis_q        <= 2'd0;
      cnt_q         <= 8'd0;
      cap_x_q       <= 10'd0;
      cap_y_q       <= 10'd0;
      cap_z_q       <= 10'd0;
      res_x_q       <= 16'h0000;
      res_y_q       <= 16'h0000;
      core_x_in_q   <= 16'h0000;
      core_y_in_q   <= 16'h0000;
      core_start_q  <= 1'b0;
      x_phase_q     <= 16'h0000;
      y_phase_q     <= 16'h0000;
      z_phase_q     <= 16'h0000;
      phase_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      core_start_q  <= 1'b0;
      phase_valid_q <= 1'b0;

      // A set event in the same cycle as clr_flags keeps the flag set
      if (drop_s) begin
        overrun_q <= 1'b1;
      end else if (clr_flags) begin
        overrun_q <= 1'b0;
      end else begin
        overrun_q <= overrun_q;
      end
      if (timeout_s) begin
        timeout_err_q <= 1'b1;
      end else if (clr_flags) begin
        timeout_err_q <= 1'b0;
      end else begin
        timeout_err_q <= timeout_err_q;
      end

      case (state_q)
        S_IDLE: begin
          if (sample_stb) begin
            cap_x_q      <= x_accel_data;
            cap_y_q      <= y_accel_data;
            cap_z_q      <= z_accel_data;
            axis_q       <= AX_X;
            core_x_in_q  <= scale_op(y_accel_data);
            core_y_in_q  <= scale_op(z_accel_data);
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Ready is ignored here: it can only be a leftover from an abandoned job
          cnt_q   <= 8'd0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (job_end_s) begin
            case (axis_q)
              AX_X: res_x_q <= res_val_s;
              AX_Y: res_y_q <= res_val_s;
              default: begin
                x_phase_q     <= res_x_q;
                y_phase_q     <= res_y_q;
                z_phase_q     <= res_val_s;
                phase_valid_q <= 1'b1;
              end
            endcase
            if (axis_q == AX_Z) begin
              state_q <= S_DONE;
            end else begin
              axis_q       <= axis_d;
              core_x_in_q  <= op_x_d;
              core_y_in_q  <= op_y_d;
              core_start_q <= 1'b1;
              state_q      <= S_ISSUE;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign core_x_in   = core_x_in_q;
  assign core_y_in   = core_y_in_q;
  assign core_start  = core_start_q;
  assign x_phase     = x_phase_q;
  assign y_phase     = y_phase_q;
  assign z_phase     = z_phase_q;
  assign phase_valid = phase_valid_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_accel_atan_sequencer.sv
// Bench for accel_atan_sequencer: a behavioural arctan core with programmable
// latency answers the jobs. Expected operands, phases, pulse timing and flags
// come from plain-arithmetic reference rules.
module tb_accel_atan_sequencer;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        RST;
  logic        sample_stb;
  logic [9:0]  x_accel_data, y_accel_data, z_accel_data;
  logic [15:0] core_x_in, core_y_in;
  logic        core_start;
  logic [15:0] core_phase;
  logic        core_rdy;
  logic [15:0] x_phase, y_phase, z_phase;
  logic        phase_valid, busy, timeout_err, overrun;
  logic        clr_flags;

  logic        core_rdy_m = 1'b0;
  logic [15:0] core_phase_m = 16'h0000;
  logic        stale_rdy;

  assign core_rdy   = core_rdy_m | stale_rdy;
  assign core_phase = stale_rdy ? 16'hDEAD : core_phase_m;

  always #5 clk = ~clk;

  accel_atan_sequencer #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .RST          (RST),
    .sample_stb   (sample_stb),
    .x_accel_data (x_accel_data),
    .y_accel_data (y_accel_data),
    .z_accel_data (z_accel_data),
    .core_x_in    (core_x_in),
    .core_y_in    (core_y_in),
    .core_start   (core_start),
    .core_phase   (core_phase),
    .core_rdy     (core_rdy),
    .x_phase      (x_phase),
    .y_phase      (y_phase),
    .z_phase      (z_phase),
    .phase_valid  (phase_valid),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .overrun      (overrun),
    .clr_flags    (clr_flags)
  );

  int          total = 0;
  int          bad   = 0;
  int          lat   = 3;
  int          start_cnt = 0;
  int          cnt_m = 0;
  int          cur_job = 0;
  logic [15:0] log_x [256];
  logic [15:0] log_y [256];
  logic [15:0] job_phase [256];
  bit          no_ans [256];
  bit          exp_to = 1'b0;
  bit          exp_ov = 1'b0;
  bit          force_ph = 1'b0;
  logic [15:0] last_ph [3];

  // Single comparison point: counts and reports mismatches
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Spec rule: m = {a[7:2],00}*164 mod 2^16, s = m/2, negate when a[9] set
  function automatic logic [15:0] ref_op(input logic [9:0] a);
    int mag;
    int s;
    mag = int'(a[7:2]) * 4 * 164;
    s = (mag % 65536) / 2;
    if (a[9]) s = (65536 - s) % 65536;
    return 16'(s);
  endfunction

  // Behavioural arctan core: logs each job and answers lat cycles later unless silenced
  always @(negedge clk) begin
    if (!RST) begin
      cnt_m      <= 0;
      core_rdy_m <= 1'b0;
    end else begin
      core_rdy_m <= (cnt_m == 1);
      if (cnt_m == 1) core_phase_m <= job_phase[cur_job];
      if (core_start) begin
        log_x[start_cnt % 256] <= core_x_in;
        log_y[start_cnt % 256] <= core_y_in;
        cur_job   <= start_cnt % 256;
        cnt_m     <= no_ans[start_cnt % 256] ? 0 : lat;
        start_cnt <= start_cnt + 1;
      end else if (cnt_m > 0) begin
        cnt_m <= cnt_m - 1;
      end
    end
  end

  // One conversion set from strobe to DONE, with optional drop/overrun/stale-ready injections
  task automatic run_set(input logic [9:0] xw, input logic [9:0] yw, input logic [9:0] zw,
                         input int drop_job, input int ovr_mode, input bit stale);
    int base;
    int n;
    int exp_done;
    int idx;
    bit seen;
    logic [9:0] w [3];
    logic [15:0] ph;
    w[0] = xw; w[1] = yw; w[2] = zw;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_pv", 32'(phase_valid), 32'd0);
    base = start_cnt;
    exp_done = 1;
    for (int j = 0; j < 3; j++) begin
      idx = (base + j) % 256;
      job_phase[idx] = force_ph ? 16'(273 * (j + 1)) : 16'($urandom_range(1, 65535));
      no_ans[idx] = (j == drop_job);
      exp_done += (j == drop_job) ? (TO + 1) : (lat + 1);
    end
    x_accel_data = xw; y_accel_data = yw; z_accel_data = zw;
    sample_stb = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      x_accel_data = 10'($urandom);
      y_accel_data = 10'($urandom);
      z_accel_data = 10'($urandom);
      sample_stb = ((ovr_mode == 1) && (n == 2 || n == exp_done)) || ((ovr_mode == 2) && (n == 2));
      clr_flags  = (ovr_mode == 2) && (n == 2);
      stale_rdy  = stale && (n == 1 || n == lat + 2);
      if (n == 1) chk("busy_rise", 32'(busy), 32'd1);
      if (phase_valid) seen = 1'b1;
    end
    stale_rdy = 1'b0;
    clr_flags = 1'b0;
    chk("pv_cycle", 32'(n), 32'(exp_done));
    chk("busy_done", 32'(busy), 32'd1);
    for (int j = 0; j < 3; j++) begin
      idx = (base + j) % 256;
      last_ph[j] = (j == drop_job) ? 16'h0000 : job_phase[idx];
      chk("op_x", 32'(log_x[idx]), 32'(ref_op(w[(j + 1) % 3])));
      chk("op_y", 32'(log_y[idx]), 32'(ref_op(w[(j + 2) % 3])));
    end
    chk("x_phase", 32'(x_phase), 32'(last_ph[0]));
    chk("y_phase", 32'(y_phase), 32'(last_ph[1]));
    ph = z_phase;
    chk("z_phase", 32'(ph), 32'(last_ph[2]));
    chk("starts", 32'(start_cnt - base), 32'd3);
    if (ovr_mode == 1) begin
      @(negedge clk);
      sample_stb = 1'b0;
      chk("pv_one_cycle", 32'(phase_valid), 32'd0);
      chk("busy_fall", 32'(busy), 32'd0);
    end else begin
      sample_stb = 1'b0;
    end
    if (ovr_mode == 2) exp_to = 1'b0;
    if (drop_job >= 0) exp_to = 1'b1;
    if (ovr_mode != 0) exp_ov = 1'b1;
    chk("timeout_err", 32'(timeout_err), 32'(exp_to));
    chk("overrun", 32'(overrun), 32'(exp_ov));
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    exp_to = 1'b0;
    exp_ov = 1'b0;
    chk("clr_to", 32'(timeout_err), 32'd0);
    chk("clr_ov", 32'(overrun), 32'd0);
  endtask

  initial begin
    int b;
    RST = 1'b0;
    sample_stb = 1'b0;
    clr_flags = 1'b0;
    stale_rdy = 1'b0;
    x_accel_data = 10'd0; y_accel_data = 10'd0; z_accel_data = 10'd0;
    for (int i = 0; i < 256; i++) begin
      no_ans[i] = 1'b0;
      job_phase[i] = 16'h0000;
    end
    for (int j = 0; j < 3; j++) last_ph[j] = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(core_start), 32'd0);
    chk("rst_xin", 32'(core_x_in), 32'd0);
    chk("rst_yin", 32'(core_y_in), 32'd0);
    chk("rst_xph", 32'(x_phase), 32'd0);
    chk("rst_pv", 32'(phase_valid), 32'd0);
    chk("rst_flags", 32'({timeout_err, overrun}), 32'd0);
    RST = 1'b1;

    // Directed ordering set, L=3
    lat = 3;
    force_ph = 1'b1;
    b = start_cnt;
    run_set(10'h000, 10'h0FF, 10'h2FF, -1, 0, 1'b0);
    force_ph = 1'b0;
    chk("dir_x0", 32'(log_x[b % 256]), 32'h50B8);
    chk("dir_y0", 32'(log_y[b % 256]), 32'hAF48);
    chk("dir_x1", 32'(log_x[(b + 1) % 256]), 32'hAF48);
    chk("dir_y1", 32'(log_y[(b + 1) % 256]), 32'h0000);
    chk("dir_x2", 32'(log_x[(b + 2) % 256]), 32'h0000);
    chk("dir_y2", 32'(log_y[(b + 2) % 256]), 32'h50B8);
    chk("dir_xph", 32'(x_phase), 32'h0111);
    chk("dir_zph", 32'(z_phase), 32'h0333);

    // Timeout on the Y job
    run_set(10'($urandom), 10'($urandom), 10'($urandom), 1, 0, 1'b0);
    clear_flags();

    // Overrun: drops during X WAIT and during DONE
    lat = int'($urandom_range(2, 6));
    b = start_cnt;
    run_set(10'($urandom), 10'($urandom), 10'($urandom), -1, 1, 1'b0);
    repeat (3) @(negedge clk);
    chk("ovr_starts", 32'(start_cnt - b), 32'd3);
    clear_flags();
    // Drop coinciding with clr_flags: overrun must stay set
    run_set(10'($urandom), 10'($urandom), 10'($urandom), -1, 2, 1'b0);
    clear_flags();

    // Stale ready in IDLE, then in ISSUE cycles
    @(negedge clk);
    stale_rdy = 1'b1;
    @(negedge clk);
    stale_rdy = 1'b0;
    chk("stale_idle_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("stale_idle_pv", 32'(phase_valid), 32'd0);
    chk("stale_idle_xph", 32'(x_phase), 32'(last_ph[0]));
    lat = int'($urandom_range(1, 6));
    run_set(10'($urandom), 10'($urandom), 10'($urandom), -1, 0, 1'b1);

    // Reset during the Z WAIT
    lat = 4;
    b = start_cnt;
    for (int j = 0; j < 3; j++) no_ans[(b + j) % 256] = 1'b0;
    @(negedge clk);
    x_accel_data = 10'($urandom); y_accel_data = 10'($urandom); z_accel_data = 10'($urandom);
    sample_stb = 1'b1;
    for (int k = 0; k < 2 * lat + 4; k++) begin
      @(negedge clk);
      sample_stb = 1'b0;
    end
    chk("pre_rst_busy", 32'(busy), 32'd1);
    RST = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_start", 32'(core_start), 32'd0);
    chk("mid_rst_xin", 32'(core_x_in), 32'd0);
    chk("mid_rst_phases", 32'(x_phase | y_phase | z_phase), 32'd0);
    chk("mid_rst_pv", 32'(phase_valid), 32'd0);
    repeat (2) @(negedge clk);
    RST = 1'b1;
    exp_to = 1'b0;
    exp_ov = 1'b0;
    for (int j = 0; j < 3; j++) last_ph[j] = 16'h0000;
    run_set(10'($urandom), 10'($urandom), 10'($urandom), -1, 0, 1'b0);

    // Back-to-back: second strobe in the IDLE cycle right after DONE
    lat = int'($urandom_range(1, 6));
    run_set(10'($urandom), 10'($urandom), 10'($urandom), -1, 0, 1'b0);
    run_set(10'($urandom), 10'($urandom), 10'($urandom), -1, 0, 1'b0);

    // Randomized sets with random latency and occasional silent jobs
    for (int r = 0; r < 8; r++) begin
      lat = int'($urandom_range(1, 7));
      run_set(10'($urandom), 10'($urandom), 10'($urandom),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accel_atan_sequencer.md
# accel_atan_sequencer

Time-multiplexes one shared `arctan` core across the three accelerometer tilt computations of the complementary filter, replacing three parallel core instances. On each sample strobe it:
- captures the three accelerometer words;
- issues three arctan jobs in fixed order (X, then Y, then Z) over a start/ready handshake;
- collects each phase result, then presents all three together with a one-cycle valid pulse to the degree-conversion and filter stage.

## Interface
Parameters:
- `TIMEOUT`, 64 — maximum WAIT cycles per job before the job is abandoned; range 2..255.

Ports:
- `clk`  in  1  — system clock.
- `RST`  in  1  — reset, asynchronous, active-low.
- `sample_stb`  in  1  — one-cycle request to start a conversion set.
- `x_accel_data`, `y_accel_data`, `z_accel_data`  in  10 each  — accelerometer words. Bit 9 is the sign; bits 8:0 are the magnitude.
- `core_x_in`, `core_y_in`  out  16 each  — signed operands to the shared arctan core.
- `core_start`  out  1  — one-cycle job-issue pulse to the core.
- `core_phase`  in  16  — arctan result.
- `core_rdy`  in  1  — result-valid from the core.
- `x_phase`, `y_phase`, `z_phase`  out  16 each  — latched results of the last completed set.
- `phase_valid`  out  1  — one-cycle pulse; the three phase outputs updated this cycle.
- `busy`  out  1  — high in every state except IDLE.
- `timeout_err`  out  1  — sticky; set when any job times out.
- `overrun`  out  1  — sticky; set when a `sample_stb` is dropped.
- `clr_flags`  in  1  — clears both sticky flags.

## Operation
Reset (RST low, takes effect immediately):
- State goes to IDLE.
- Every output and every internal register goes to 0.

State machine: IDLE → ISSUE → WAIT → (next ISSUE | DONE) → IDLE.
- **IDLE:** `sample_stb`=1 latches all three accel words into capture registers. Axis index ← X. Next state ISSUE.
- **ISSUE** (one cycle):
  - `core_start`=1.
  - `core_x_in`/`core_y_in` hold the job operands, and stay stable through the end of WAIT.
  - WAIT counter is cleared.
  - `core_rdy` is ignored in this cycle.
  - Next state WAIT.
- **WAIT:**
  - On `core_rdy`=1, store `core_phase` into the current axis result register.
  - If the counter reaches `TIMEOUT` with no `core_rdy`, store 16'h0000 for that axis and set `timeout_err`.
  - After either event, advance to the next axis in ISSUE. After Z, go to DONE.
- **DONE** (one cycle):
  - Copy all three result registers to `x_phase`/`y_phase`/`z_phase`.
  - `phase_valid`=1.
  - Next state IDLE.

Job operand pairing (x_in, y_in):
- X job: (y, z).
- Y job: (z, x).
- Z job: (x, y).

Operand scaling for an accel word `a`:
- `m` = {a[7:2], 2'b00} × 164, computed as an unsigned 16-bit product. Maximum 41328.
- `s` = m >> 1. Maximum 20664, so it fits signed 16-bit.
- Operand = a[9] ? −s : s, in two's complement.
- a[8] is ignored.

Boundary conditions:
- `sample_stb` while `busy`=1 (including the DONE cycle): the strobe is dropped, `overrun` is set, and the in-flight set is unaffected.
- `core_rdy` in IDLE, ISSUE or DONE: ignored.
- A late `core_rdy` arriving after a timeout belongs to the abandoned job. It is ignored only while in ISSUE; the core must not deliver stale results once the next job is in WAIT.
- `clr_flags` in the same cycle as a set event: the set wins.
- Input accel words may change during a set. Only the values captured in IDLE are used.

## Timing
- Let E0 be the edge at which `sample_stb` is sampled high. Let L ≥ 1 be the core latency, meaning `core_rdy` is sampled high L cycles after the edge ending the ISSUE cycle.
- Job issue cycles start at E0+1, E0+L+2 and E0+2L+3. Each job takes L+1 cycles.
- DONE, with `phase_valid` high, occurs in cycle E0+3L+4. The phase outputs change at the same edge.
- After DONE, the next `sample_stb` can be accepted at the following edge.
- With a timeout, that job's duration is `TIMEOUT`+1 cycles in place of L+1.
- `busy` rises in the cycle after E0 and falls in the cycle after DONE.

## Test plan
- **Basic ordering, L=3:**
  - Stimulus: x=10'h000, y=10'h0FF, z=10'h2FF, one strobe.
  - Expected X job: `core_x_in`=16'h50B8, `core_y_in`=16'hAF48.
  - Expected Y job: (16'hAF48, 16'h0000).
  - Expected Z job: (16'h0000, 16'h50B8).
  - Core returns phases 16'h0111, 16'h0222, 16'h0333. `phase_valid` must fire at E0+13 with exactly those three values in x, y, z order.
- **Timeout:**
  - Stimulus: `TIMEOUT`=8; core never answers the Y job.
  - Required: `y_phase`=0, X and Z phases correct, `timeout_err`=1. `phase_valid` fires 8+1−(L+1) cycles later than the nominal E0+3L+4.
- **Overrun:**
  - Stimulus: second `sample_stb` during WAIT of the X job, and another during DONE.
  - Required: exactly three `core_start` pulses, `overrun`=1, one `phase_valid`.
  - Then `clr_flags` → `overrun`=0. If `clr_flags` coincides with a new drop, `overrun` stays 1.
- **Reset mid-set:**
  - Stimulus: RST low during the Z WAIT.
  - Required: all outputs 0 immediately, including `busy`, `core_start` and the phase outputs.
  - After release, a new strobe runs a full clean set.
- **Stale ready:**
  - Stimulus: `core_rdy` pulsed in IDLE and in an ISSUE cycle.
  - Required: no result capture and no state advance.
- **Back-to-back:**
  - Stimulus: strobe in the cycle right after DONE.
  - Required: accepted with no overrun, and both sets produce correct results.
